shift_serializer: RTL and testbench



---
 rtl/shift_serializer.sv | 127 ++++++++++++
 tb/tb_shift_serializer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_serializer.sv
// shift_serializer: parallel-in, serial-out transmitter, MSB first, one bit per shift_enable tick.
// Latency: first bit appears on the first enabled edge after the accept edge; throughput one bit per enabled cycle.
// Backpressure: load_ready is high only in IDLE; load_valid is ignored while a frame is in flight.
//
// Optional feature: define SHIFT_SERIALIZER_PARITY_EN to append an even-parity bit
// after the data bits (frame becomes WIDTH+1 bits, frame_done moves to the parity bit).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (overrides everything)
//   load_data    WIDTH-bit word to transmit
//   load_valid   load_data is valid
//   load_ready   block can accept a word (state == IDLE)
//   shift_enable bit-rate tick; one bit per high cycle while shifting
//   serial_data  registered serial bit, MSB first; holds last bit in IDLE
//   serial_valid one-cycle strobe per emitted bit
//   busy         frame in progress (state != IDLE)
//   frame_done   one-cycle pulse with the last bit of a frame

module shift_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_enable,
  output logic             serial_data,
  output logic             serial_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SHIFT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] bit_cnt;
`ifdef SHIFT_SERIALIZER_PARITY_EN
  logic             parity_bit;
`endif

  // Handshake status is a pure decode of the state register, so it changes
  // on the same edges as the state itself.
  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sr           <= '0;
      bit_cnt      <= '0;
      serial_data  <= 1'b0;
      serial_valid <= 1'b0;
      frame_done   <= 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      // Strobes default low so each is high for exactly one cycle per event.
      serial_valid <= 1'b0;
      frame_done   <= 1'b0;

      case (state)
        IDLE: begin
          // shift_enable is deliberately ignored here: the accept cycle
          // never emits a bit.
          if (load_valid) begin
            sr      <= load_data;
            bit_cnt <= '0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            parity_bit <= ^load_data;
`endif
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (shift_enable) begin
            serial_data  <= sr[WIDTH-1];
            serial_valid <= 1'b1;
            sr           <= {sr[WIDTH-2:0], 1'b0};
            bit_cnt      <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
              // Frame continues with the parity bit; frame_done waits for it.
              state      <= PARITY;
`else
              frame_done <= 1'b1;
              state      <= IDLE;
`endif
            end
          end
        end

`ifdef SHIFT_SERIALIZER_PARITY_EN
        PARITY: begin
          if (shift_enable) begin
            serial_data  <= parity_bit;
            serial_valid <= 1'b1;
            frame_done   <= 1'b1;
            state        <= IDLE;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: randomized and directed stimulus against a queue-based
// reference model of the serial frame, plus a receiver that collects words.
// One monitor process updates the model and compares every cycle.

module tb_shift_serializer;

  localparam int WIDTH = 8;
`ifdef SHIFT_SERIALIZER_PARITY_EN
  localparam int FB = WIDTH + 1;
`else
  localparam int FB = WIDTH;
`endif

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_enable;
  logic             serial_data;
  logic             serial_valid;
  logic             busy;
  logic             frame_done;

  shift_serializer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .shift_enable(shift_enable),
    .serial_data (serial_data),
    .serial_valid(serial_valid),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just a queue of bits still to be sent.
  bit   m_bits[$];
  bit   m_busy  = 1'b0;
  bit   m_data  = 1'b0;
  bit   m_valid = 1'b0;
  bit   m_done  = 1'b0;

  // Receiver / observation state, cleared by the directed tests.
  logic [FB-1:0]    rx = '0;
  logic [WIDTH-1:0] words[$];
  bit               rx_bits[$];
  int               vcyc[$];
  int               done_cyc[$];
  int               busy_cnt = 0;
  int               cyc = 0;

  task automatic clear_obs();
    words.delete();
    rx_bits.delete();
    vcyc.delete();
    done_cyc.delete();
    busy_cnt = 0;
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      m_bits.delete();
      m_busy  = 1'b0;
      m_data  = 1'b0;
      m_valid = 1'b0;
      m_done  = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (!m_busy) begin
        if (load_valid) begin
          for (int i = WIDTH - 1; i >= 0; i--) m_bits.push_back(load_data[i]);
`ifdef SHIFT_SERIALIZER_PARITY_EN
          m_bits.push_back(^load_data);
`endif
          m_busy = 1'b1;
        end
      end else if (shift_enable) begin
        m_data  = m_bits.pop_front();
        m_valid = 1'b1;
        if (m_bits.size() == 0) begin
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
    chk("serial_data",  {31'd0, serial_data},  {31'd0, m_data});
    chk("serial_valid", {31'd0, serial_valid}, {31'd0, m_valid});
    chk("frame_done",   {31'd0, frame_done},   {31'd0, m_done});
    chk("busy",         {31'd0, busy},         {31'd0, m_busy});
    chk("load_ready",   {31'd0, load_ready},   {31'd0, !m_busy});

    if (serial_valid === 1'b1) begin
      rx = {rx[FB-2:0], serial_data};
      rx_bits.push_back(serial_data);
      vcyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      words.push_back(rx[FB-1:FB-WIDTH]);
      done_cyc.push_back(cyc);
    end
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic drive(input bit r, input bit lv, input logic [WIDTH-1:0] ld, input bit se);
    @(negedge clk);
    reset        = r;
    load_valid   = lv;
    load_data    = ld;
    shift_enable = se;
  endtask

  // Runs idle cycles with shift_enable held until the frame ends.
  task automatic run_to_idle(input string name, input int budget);
    int n = 0;
    do begin
      drive(0, 0, '0, 1);
      n++;
    end while (busy && n < budget);
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  logic [WIDTH-1:0] lit;

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; shift_enable = 1'b0;
    drive(1, 0, '0, 0);
    drive(0, 0, '0, 0);
    // Reset values, pinned with literals.
    chk("rst_busy",       {31'd0, busy},         32'd0);
    chk("rst_load_ready", {31'd0, load_ready},   32'd1);
    chk("rst_serial_vld", {31'd0, serial_valid}, 32'd0);
    chk("rst_serial_dat", {31'd0, serial_data},  32'd0);
    chk("rst_frame_done", {31'd0, frame_done},   32'd0);

    // Basic frame: A5 with shift_enable constantly high.
    clear_obs();
    drive(0, 1, 8'hA5, 1);
    run_to_idle("basic", 40);
    lit = 8'hA5;
    chk("basic_nbits", rx_bits.size(), FB);
    for (int i = 0; i < WIDTH; i++)
      if (i < rx_bits.size()) chk("basic_bit", {31'd0, rx_bits[i]}, {31'd0, lit[WIDTH-1-i]});
    chk("basic_ndone", words.size(), 1);
    if (words.size() > 0) chk("basic_word", {24'd0, words[0]}, 32'hA5);
    if (done_cyc.size() > 0 && vcyc.size() == FB) chk("basic_done_last", done_cyc[0], vcyc[FB-1]);

    // Gapped enable: every 3rd cycle.
    clear_obs();
    drive(0, 1, 8'h3C, 0);
    begin
      int k = 0;
      do begin
        k++;
        drive(0, 0, '0, (k % 3 == 0));
      end while (busy && k < 100);
    end
    chk("gap_busy_cycles", busy_cnt, 3 * FB);
    if (words.size() > 0) chk("gap_word", {24'd0, words[0]}, 32'h3C);

    // Back-to-back with load_valid held.
    clear_obs();
    drive(0, 1, 8'hFF, 1);
    begin
      int n = 0;
      do begin
        drive(0, 1, 8'h01, 1);
        n++;
      end while (done_cyc.size() == 0 && n < 40);
    end
    drive(0, 0, '0, 1);
    run_to_idle("b2b", 40);
    chk("b2b_nwords", words.size(), 2);
    if (words.size() == 2) begin
      chk("b2b_word0", {24'd0, words[0]}, 32'hFF);
      chk("b2b_word1", {24'd0, words[1]}, 32'h01);
    end
    if (vcyc.size() == 2 * FB) chk("b2b_gap", vcyc[FB] - vcyc[FB-1], 2);

    // Ignored load during a frame.
    clear_obs();
    drive(0, 1, 8'h81, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 8'h7E, 1);
    run_to_idle("ign", 40);
    drive(0, 0, '0, 1);
    drive(0, 0, '0, 1);
    chk("ign_nwords", words.size(), 1);
    if (words.size() > 0) chk("ign_word", {24'd0, words[0]}, 32'h81);
    chk("ign_busy_after", {31'd0, busy}, 32'd0);

    // Mid-frame reset after 4 bits.
    clear_obs();
    drive(0, 1, 8'hF0, 1);
    begin
      int n = 0;
      do begin
        drive(0, 0, '0, 1);
        n++;
      end while (vcyc.size() < 4 && n < 20);
    end
    drive(1, 0, '0, 1);
    drive(0, 0, '0, 0);
    chk("mrst_busy",       {31'd0, busy},         32'd0);
    chk("mrst_load_ready", {31'd0, load_ready},   32'd1);
    chk("mrst_serial_vld", {31'd0, serial_valid}, 32'd0);
    chk("mrst_no_done",    done_cyc.size(),       0);
    clear_obs();
    drive(0, 1, 8'h0F, 1);
    run_to_idle("mrst", 40);
    chk("mrst_nwords", words.size(), 1);
    if (words.size() > 0) chk("mrst_word", {24'd0, words[0]}, 32'h0F);

    // Parity / frame length with 07.
    clear_obs();
    drive(0, 1, 8'h07, 1);
    run_to_idle("par", 40);
    drive(0, 0, '0, 1);
    drive(0, 0, '0, 1);
    chk("par_nbits", rx_bits.size(), FB);
    chk("par_ndone", done_cyc.size(), 1);
    if (done_cyc.size() > 0 && vcyc.size() > 0) chk("par_done_last", done_cyc[0], vcyc[vcyc.size()-1]);
`ifdef SHIFT_SERIALIZER_PARITY_EN
    if (rx_bits.size() == 9) chk("par_bit9", {31'd0, rx_bits[8]}, 32'd1);
`endif

    // Randomized traffic; the monitor model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
            WIDTH'($urandom), ($urandom_range(0, 9) < 6));
    end
    drive(0, 0, '0, 0);
    drive(0, 0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
